// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data-memory and bus-side handshake signals of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_resp_rdata;
  logic              if_flush;

  logic              dm_req_valid;
  logic              dm_req_wen;
  logic [ADDR_W-1:0] dm_req_addr;
  logic [DATA_W-1:0] dm_req_wdata;
  logic [STRB_W-1:0] dm_req_wstrb;
  logic              dm_req_ready;
  logic              dm_resp_valid;
  logic [DATA_W-1:0] dm_resp_rdata;

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_req_wen;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [DATA_W-1:0] bus_req_wdata;
  logic [STRB_W-1:0] bus_req_wstrb;
  logic              bus_resp_valid;
  logic [DATA_W-1:0] bus_resp_rdata;

  modport slave (
    input  if_req_valid, if_req_addr, if_flush,
    input  dm_req_valid, dm_req_wen, dm_req_addr, dm_req_wdata, dm_req_wstrb,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata,
    output if_req_ready, if_resp_valid, if_resp_rdata,
    output dm_req_ready, dm_resp_valid, dm_resp_rdata,
    output bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wstrb
  );

  modport master (
    output if_req_valid, if_req_addr, if_flush,
    output dm_req_valid, dm_req_wen, dm_req_addr, dm_req_wdata, dm_req_wstrb,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata,
    input  if_req_ready, if_resp_valid, if_resp_rdata,
    input  dm_req_ready, dm_resp_valid, dm_resp_rdata,
    input  bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and data memory, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise DM has fixed priority over IF.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input logic               clk,
  input logic               resetn,
  mem_port_arbiter_if.slave port
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
  typedef enum logic {OWN_DM = 1'b0, OWN_IF = 1'b1} owner_e;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_req_t;

  state_e   state_q, state_d;
  owner_e   owner_q, owner_d;
  logic     drop_q, drop_d;
  bus_req_t req_q, req_d;
`ifdef ARB_ROUND_ROBIN_EN
  owner_e   last_q, last_d;
`endif

  logic if_elig, dm_elig, pick_if;
  logic if_ready_c, dm_ready_c, resp_fire_c;

  // Next-state, arbitration and handshake decode
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    req_d       = req_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    if_ready_c  = 1'b0;
    dm_ready_c  = 1'b0;
    pick_if     = 1'b0;
    resp_fire_c = 1'b0;
    if_elig     = port.if_req_valid && !port.if_flush;
    dm_elig     = port.dm_req_valid;

    unique case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (resetn && (if_elig || dm_elig)) begin
`ifdef ARB_ROUND_ROBIN_EN
          pick_if = if_elig && (!dm_elig || (last_q == OWN_DM));
          last_d  = pick_if ? OWN_IF : OWN_DM;
`else
          pick_if = !dm_elig;
`endif
          state_d = S_ISSUE;
          if (pick_if) begin
            if_ready_c = 1'b1;
            owner_d    = OWN_IF;
            req_d      = '{wen: 1'b0, addr: port.if_req_addr, wdata: '0, wstrb: '0};
          end else begin
            dm_ready_c = 1'b1;
            owner_d    = OWN_DM;
            req_d      = '{wen:   port.dm_req_wen,   addr:  port.dm_req_addr,
                           wdata: port.dm_req_wdata, wstrb: port.dm_req_wstrb};
          end
        end
      end
      S_ISSUE: begin
        if (port.if_flush && (owner_q == OWN_IF)) drop_d = 1'b1;
        if (port.bus_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (port.if_flush && (owner_q == OWN_IF)) drop_d = 1'b1;
        if (port.bus_resp_valid) begin
          resp_fire_c = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      owner_q <= OWN_DM;
      drop_q  <= 1'b0;
      req_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= OWN_DM;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  // A flush arriving in the response cycle itself also suppresses the fetch response
  assign port.if_req_ready  = if_ready_c;
  assign port.dm_req_ready  = dm_ready_c;
  assign port.if_resp_valid = resp_fire_c && (owner_q == OWN_IF) && !drop_q && !port.if_flush;
  assign port.dm_resp_valid = resp_fire_c && (owner_q == OWN_DM);
  assign port.if_resp_rdata = port.if_resp_valid ? port.bus_resp_rdata : '0;
  assign port.dm_resp_rdata = port.dm_resp_valid ? port.bus_resp_rdata : '0;

  assign port.bus_req_valid = (state_q == S_ISSUE);
  assign port.bus_req_wen   = req_q.wen;
  assign port.bus_req_addr  = req_q.addr;
  assign port.bus_req_wdata = req_q.wdata;
  assign port.bus_req_wstrb = req_q.wstrb;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle vector table plus hand sequences for flush, reset and contention.
module tb_mem_port_arbiter;
  logic clk;
  logic resetn;
  int   total;
  int   bad;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) port ();

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk    (clk),
    .resetn (resetn),
    .port   (port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected test done before it");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        rstn, if_v, flush, dm_v, wen, brdy, rspv;
    logic [63:0] addr;
    logic [7:0]  wstrb;
    logic [63:0] data;
    logic        e_ifr, e_dmr, e_bv, e_ifv, e_dmv;
    logic [63:0] e_baddr;
    logic        e_bwen;
    logic [7:0]  e_bstrb;
    logic [63:0] e_bwdata;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    resetn              = 1'b1;
    port.if_req_valid   = 1'b0;
    port.if_req_addr    = '0;
    port.if_flush       = 1'b0;
    port.dm_req_valid   = 1'b0;
    port.dm_req_wen     = 1'b0;
    port.dm_req_addr    = '0;
    port.dm_req_wdata   = '0;
    port.dm_req_wstrb   = '0;
    port.bus_req_ready  = 1'b0;
    port.bus_resp_valid = 1'b0;
    port.bus_resp_rdata = '0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk1({nm, ".if_rdy"}, port.if_req_ready, 1'b0);
    chk1({nm, ".dm_rdy"}, port.dm_req_ready, 1'b0);
    chk1({nm, ".bus_v"}, port.bus_req_valid, 1'b0);
    chk1({nm, ".if_rv"}, port.if_resp_valid, 1'b0);
    chk1({nm, ".dm_rv"}, port.dm_resp_valid, 1'b0);
    chk1({nm, ".bus_wen"}, port.bus_req_wen, 1'b0);
    chk64({nm, ".bus_addr"}, port.bus_req_addr, 64'h0);
    chk64({nm, ".bus_wdata"}, port.bus_req_wdata, 64'h0);
    chk64({nm, ".bus_wstrb"}, 64'(port.bus_req_wstrb), 64'h0);
    chk64({nm, ".if_rdata"}, port.if_resp_rdata, 64'h0);
    chk64({nm, ".dm_rdata"}, port.dm_resp_rdata, 64'h0);
  endtask

  // Drive one cycle of inputs after the falling edge, check outputs before the next rising edge
  task automatic apply(input vec_t v);
    @(negedge clk);
    resetn              = v.rstn;
    port.if_req_valid   = v.if_v;
    port.if_req_addr    = v.addr;
    port.if_flush       = v.flush;
    port.dm_req_valid   = v.dm_v;
    port.dm_req_wen     = v.wen;
    port.dm_req_addr    = v.addr;
    port.dm_req_wdata   = v.data;
    port.dm_req_wstrb   = v.wstrb;
    port.bus_req_ready  = v.brdy;
    port.bus_resp_valid = v.rspv;
    port.bus_resp_rdata = v.data;
    #1;
    chk1({v.name, ".if_rdy"}, port.if_req_ready, v.e_ifr);
    chk1({v.name, ".dm_rdy"}, port.dm_req_ready, v.e_dmr);
    chk1({v.name, ".bus_v"}, port.bus_req_valid, v.e_bv);
    chk1({v.name, ".if_rv"}, port.if_resp_valid, v.e_ifv);
    chk1({v.name, ".dm_rv"}, port.dm_resp_valid, v.e_dmv);
    if (v.e_bv) begin
      chk64({v.name, ".bus_addr"}, port.bus_req_addr, v.e_baddr);
      chk1({v.name, ".bus_wen"}, port.bus_req_wen, v.e_bwen);
      chk64({v.name, ".bus_wstrb"}, 64'(port.bus_req_wstrb), 64'(v.e_bstrb));
      chk64({v.name, ".bus_wdata"}, port.bus_req_wdata, v.e_bwdata);
    end
    if (v.e_ifv) chk64({v.name, ".if_rdata"}, port.if_resp_rdata, v.e_rdata);
    if (v.e_dmv) chk64({v.name, ".dm_rdata"}, port.dm_resp_rdata, v.e_rdata);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //        name       rstn ifv fl dmv wen brdy rspv addr               wstrb  data
    //                   e_ifr e_dmr e_bv e_ifv e_dmv e_baddr          e_bwen e_bstrb e_bwdata               e_rdata
    vecs[0]  = '{"ld_acc",  1,0,0,1,0,1,0, 64'h80000010, 8'h00, 64'h0,
                 0,1,0,0,0, 64'h0, 0, 8'h00, 64'h0, 64'h0};
    vecs[1]  = '{"ld_iss",  1,0,0,0,0,1,0, 64'h0, 8'h00, 64'h0,
                 0,0,1,0,0, 64'h80000010, 0, 8'h00, 64'h0, 64'h0};
    vecs[2]  = '{"ld_rsp",  1,0,0,0,0,0,1, 64'h0, 8'h00, 64'hDEADBEEF_CAFEF00D,
                 0,0,0,0,1, 64'h0, 0, 8'h00, 64'h0, 64'hDEADBEEF_CAFEF00D};
    vecs[3]  = '{"ld_idle", 1,0,0,0,0,0,0, 64'h0, 8'h00, 64'h0,
                 0,0,0,0,0, 64'h0, 0, 8'h00, 64'h0, 64'h0};
    vecs[4]  = '{"fl_idle", 1,1,1,0,0,0,0, 64'h3000, 8'h00, 64'h0,
                 0,0,0,0,0, 64'h0, 0, 8'h00, 64'h0, 64'h0};
    vecs[5]  = '{"fl_next", 1,0,0,0,0,0,0, 64'h0, 8'h00, 64'h0,
                 0,0,0,0,0, 64'h0, 0, 8'h00, 64'h0, 64'h0};
    vecs[6]  = '{"st_acc",  1,0,0,1,1,0,0, 64'h80000020, 8'h0F, 64'h11223344_55667788,
                 0,1,0,0,0, 64'h0, 0, 8'h00, 64'h0, 64'h0};
    vecs[7]  = '{"st_hold1",1,1,0,1,0,0,0, 64'h99, 8'hFF, 64'hFFFFFFFF_FFFFFFFF,
                 0,0,1,0,0, 64'h80000020, 1, 8'h0F, 64'h11223344_55667788, 64'h0};
    vecs[8]  = '{"st_hold2",1,1,0,1,0,0,0, 64'h99, 8'hFF, 64'hFFFFFFFF_FFFFFFFF,
                 0,0,1,0,0, 64'h80000020, 1, 8'h0F, 64'h11223344_55667788, 64'h0};
    vecs[9]  = '{"st_hold3",1,1,0,1,0,0,0, 64'h99, 8'hFF, 64'hFFFFFFFF_FFFFFFFF,
                 0,0,1,0,0, 64'h80000020, 1, 8'h0F, 64'h11223344_55667788, 64'h0};
    vecs[10] = '{"st_go",   1,1,0,1,0,1,0, 64'h99, 8'hFF, 64'hFFFFFFFF_FFFFFFFF,
                 0,0,1,0,0, 64'h80000020, 1, 8'h0F, 64'h11223344_55667788, 64'h0};
    vecs[11] = '{"st_rsp",  1,1,0,1,0,0,1, 64'h99, 8'hFF, 64'hA5A5A5A5_5A5A5A5A,
                 0,0,0,0,1, 64'h0, 0, 8'h00, 64'h0, 64'hA5A5A5A5_5A5A5A5A};
    vecs[12] = '{"st_late", 1,0,0,0,0,0,1, 64'h0, 8'h00, 64'h12345678,
                 0,0,0,0,0, 64'h0, 0, 8'h00, 64'h0, 64'h0};

    clear_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_inputs();
    #1;
    chk_all_zero("reset");

    for (int i = 0; i < 13; i++) apply(vecs[i]);

    // Reset while waiting for a response; a late response must not leak out
    @(negedge clk); clear_inputs();
    port.dm_req_valid = 1'b1; port.dm_req_addr = 64'h500; #1;
    chk1("rw_acc.dm_rdy", port.dm_req_ready, 1'b1);
    @(negedge clk); clear_inputs(); port.bus_req_ready = 1'b1; #1;
    chk1("rw_iss.bus_v", port.bus_req_valid, 1'b1);
    @(negedge clk); clear_inputs(); resetn = 1'b0; #1;
    chk1("rw_rst.dm_rv", port.dm_resp_valid, 1'b0);
    @(negedge clk); clear_inputs(); #1;
    chk_all_zero("rw_after");
    @(negedge clk); clear_inputs();
    port.bus_resp_valid = 1'b1; port.bus_resp_rdata = 64'hBAD0BAD0_BAD0BAD0; #1;
    chk1("rw_late.dm_rv", port.dm_resp_valid, 1'b0);
    chk1("rw_late.if_rv", port.if_resp_valid, 1'b0);

    // Flush during WAIT drops the fetch response, next fetch completes normally
    @(negedge clk); clear_inputs();
    port.if_req_valid = 1'b1; port.if_req_addr = 64'h1000; #1;
    chk1("fw_acc.if_rdy", port.if_req_ready, 1'b1);
    @(negedge clk); clear_inputs(); port.bus_req_ready = 1'b1; #1;
    chk1("fw_iss.bus_v", port.bus_req_valid, 1'b1);
    chk64("fw_iss.bus_addr", port.bus_req_addr, 64'h1000);
    @(negedge clk); clear_inputs(); port.if_flush = 1'b1; #1;
    chk1("fw_flush.if_rv", port.if_resp_valid, 1'b0);
    @(negedge clk); clear_inputs();
    port.bus_resp_valid = 1'b1; port.bus_resp_rdata = 64'h0BAD_F00D; #1;
    chk1("fw_rsp.if_rv", port.if_resp_valid, 1'b0);
    chk1("fw_rsp.dm_rv", port.dm_resp_valid, 1'b0);
    @(negedge clk); clear_inputs();
    port.if_req_valid = 1'b1; port.if_req_addr = 64'h2000; #1;
    chk1("fw_acc2.if_rdy", port.if_req_ready, 1'b1);
    chk1("fw_acc2.bus_v", port.bus_req_valid, 1'b0);
    @(negedge clk); clear_inputs(); port.bus_req_ready = 1'b1; #1;
    chk64("fw_iss2.bus_addr", port.bus_req_addr, 64'h2000);
    @(negedge clk); clear_inputs();
    port.bus_resp_valid = 1'b1; port.bus_resp_rdata = 64'h01234567_89ABCDEF; #1;
    chk1("fw_rsp2.if_rv", port.if_resp_valid, 1'b1);
    chk64("fw_rsp2.if_rdata", port.if_resp_rdata, 64'h01234567_89ABCDEF);

    // Contention: the previous grant went to IF
    for (int i = 0; i < 4; i++) begin
      logic        exp_dm;
      logic [63:0] a_if, a_dm, rd;
`ifdef ARB_ROUND_ROBIN_EN
      exp_dm = ((i % 2) == 0);
`else
      exp_dm = 1'b1;
`endif
      a_if = 64'h4000 + 64'(i * 8);
      a_dm = 64'h8000 + 64'(i * 8);
      rd   = 64'hC0DE0000 + 64'(i);
      @(negedge clk); clear_inputs();
      port.if_req_valid = 1'b1; port.if_req_addr = a_if;
      port.dm_req_valid = 1'b1; port.dm_req_addr = a_dm; #1;
      chk1($sformatf("ct%0d.dm_rdy", i), port.dm_req_ready, exp_dm);
      chk1($sformatf("ct%0d.if_rdy", i), port.if_req_ready, !exp_dm);
      @(negedge clk); clear_inputs(); port.bus_req_ready = 1'b1; #1;
      chk1($sformatf("ct%0d.bus_v", i), port.bus_req_valid, 1'b1);
      chk64($sformatf("ct%0d.bus_addr", i), port.bus_req_addr, exp_dm ? a_dm : a_if);
      @(negedge clk); clear_inputs();
      port.bus_resp_valid = 1'b1; port.bus_resp_rdata = rd; #1;
      chk1($sformatf("ct%0d.dm_rv", i), port.dm_resp_valid, exp_dm);
      chk1($sformatf("ct%0d.if_rv", i), port.if_resp_valid, !exp_dm);
      chk64($sformatf("ct%0d.rdata", i), exp_dm ? port.dm_resp_rdata : port.if_resp_rdata, rd);
    end

    @(negedge clk); clear_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory bus port between instruction fetch (IF) and data memory (DM) requesters. Accepts one request at a time, issues it on the bus, and routes the response back to the requester that owns it. Holds at most one outstanding transaction. Sits between the fetch and memory-access pipeline stages and the bus bridge. Both stages drive it with their valid/allow-in handshake.

## Interface
- ADDR_W, 64, request address width
- DATA_W, 64, data width; strobe width is DATA_W/8
- clk  in  1  clock; all state updates on posedge
- resetn  in  1  synchronous active-low reset, sampled on posedge clk
- if_req_valid  in  1  fetch request present
- if_req_addr  in  ADDR_W  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_resp_valid  out  1  fetch response pulse
- if_resp_rdata  out  DATA_W  fetch data, meaningful only while if_resp_valid
- if_flush  in  1  pipeline redirect: cancel the pending fetch
- dm_req_valid  in  1  data request present
- dm_req_wen  in  1  1 = store, 0 = load
- dm_req_addr  in  ADDR_W  data address
- dm_req_wdata  in  DATA_W  store data
- dm_req_wstrb  in  DATA_W/8  store byte enables
- dm_req_ready  out  1  data request accepted this cycle
- dm_resp_valid  out  1  data response pulse; stores also get a pulse
- dm_resp_rdata  out  DATA_W  load data
- bus_req_valid  out  1  request to bus
- bus_req_ready  in  1  bus accepts request
- bus_req_wen / bus_req_addr / bus_req_wdata / bus_req_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields
- bus_resp_valid  in  1  bus response, one cycle
- bus_resp_rdata  in  DATA_W  bus read data

## Operation
- The FSM has three states: IDLE, ISSUE and WAIT.
- **IDLE:**
  - The arbiter picks a winner from the eligible requesters.
  - IF is eligible when if_req_valid=1 and if_flush=0. DM is eligible when dm_req_valid=1.
  - The winner's *_req_ready is driven high combinationally that cycle. The request fields are latched and the owner is recorded. The next state is ISSUE.
  - The loser's ready stays 0.
- **ISSUE:**
  - bus_req_valid=1, with the latched fields held stable.
  - On bus_req_ready=1 the next state is WAIT.
  - Once bus_req_valid is asserted it is never withdrawn before bus_req_ready.
- **WAIT:**
  - On bus_resp_valid=1, owner_resp_valid = 1 for exactly that cycle, and owner_resp_rdata = bus_resp_rdata (combinational pass-through).
  - The next state is IDLE.
- **Drop flag:**
  - Set when if_flush=1 while the owner is IF in ISSUE or WAIT.
  - The bus transaction still completes, but if_resp_valid is suppressed.
  - The flag clears on return to IDLE.
  - if_flush has no effect on a DM-owned transaction.
- *_req_ready is never high outside IDLE.
- bus_resp_valid outside WAIT is ignored.
- **Reset:**
  - Synchronous, any state → IDLE. Drop flag = 0, last-grant = DM.
  - All outputs are 0 the cycle after reset is sampled low.
  - A transaction in flight is abandoned. The bus side shares this reset.

## Timing
- Request accepted in cycle N (valid&&ready).
- bus_req_valid rises at N+1.
- With bus_req_ready at N+1, the earliest bus response is at N+2.
- The response pulse appears in the same cycle as bus_resp_valid.
- The next acceptance is possible at the cycle after the response, so the minimum is 3 cycles per transaction.
- Each stall cycle of bus_req_ready or bus_resp_valid adds one cycle.

## Configuration
- ARB_ROUND_ROBIN_EN
  - **Defined:** on contention in IDLE, grant the requester not granted last. A last-grant register is updated on every grant.
  - **Undefined:** fixed priority, DM always wins over IF. No last-grant register; IF can starve while DM requests continuously.
  - In both builds a lone eligible requester is granted immediately.

## Test plan
- **Single load:**
  - Stimulus: dm_req_valid=1, wen=0, addr=0x80000010. Bus ready at once; response 0xDEADBEEF_CAFEF00D one cycle later.
  - Required: dm_req_ready at N, bus_req_valid at N+1 with addr 0x80000010, dm_resp_valid with that data at N+2, if_resp_valid=0 throughout.
- **Contention:**
  - Stimulus: if and dm valid together from IDLE, repeated for 4 transactions.
  - Required with macro: grants alternate DM, IF, DM, IF. Required without macro: DM granted all 4 times.
- **Flush in WAIT:**
  - Stimulus: IF fetch to 0x1000, if_flush=1 one cycle while in WAIT, then bus response.
  - Required: if_resp_valid stays 0 and the FSM returns to IDLE. A following fetch to 0x2000 gets its response normally.
- **Flush in IDLE:**
  - Stimulus: if_req_valid=1 with if_flush=1 in the same cycle.
  - Required: if_req_ready=0 and bus_req_valid=0 the next cycle.
- **Bus backpressure:**
  - Stimulus: store with wstrb 0x0F; bus_req_ready low for 3 cycles, then high.
  - Required: bus fields held constant for 4 cycles, then dm_resp_valid on the response. No new ready meanwhile.
- **Reset mid-WAIT:**
  - Stimulus: resetn=0 for one cycle while in WAIT.
  - Required: all outputs 0 next cycle. A late bus_resp_valid afterwards produces no response pulse.
